// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter
//   Two-requester round-robin front end for a bitwise logic unit.
//   A granted operation is captured, evaluated one cycle later, and the
//   result is held until the consumer takes it.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid / _ready       requester handshake (ready is combinational)
//   req{0,1}_a, _b [WIDTH]        operands
//   req{0,1}_op [2]               00 AND, 01 OR, 10 XOR, 11 NAND
//   res_valid / res_ready         result handshake
//   res_data [WIDTH], res_id      result and owning requester
//   busy                          block is not idle
//   done_cnt [8]                  completed result transfers (wraps)

// One result bit of the logic unit.
module logic_unit_arbiter_lane (
  input  logic       i_a,
  input  logic       i_b,
  input  logic [1:0] i_op,
  output logic       o_y
);
  always_comb begin
    o_y = 1'b0;
    unique case (i_op)
      2'b00:   o_y = i_a & i_b;
      2'b01:   o_y = i_a | i_b;
      2'b10:   o_y = i_a ^ i_b;
      default: o_y = ~(i_a & i_b);
    endcase
  end
endmodule

module logic_unit_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             id;
  } req_t;

  state_t                 r_state, w_state_nxt;
  req_t                   r_req, w_req_win;
  logic                   r_last;
  logic                   r_res_valid;
  logic [WIDTH-1:0]       r_res_data;
  logic                   r_res_id;
  logic [7:0]             r_done_cnt;

  logic [1:0]             w_req_vld;
  logic [1:0][WIDTH-1:0]  w_req_a, w_req_b;
  logic [1:0][1:0]        w_req_op;
  logic                   w_win;
  logic                   w_hs;
  logic [WIDTH-1:0]       w_result;

  assign w_req_vld = {req1_valid, req0_valid};
  assign w_req_a   = {req1_a, req0_a};
  assign w_req_b   = {req1_b, req0_b};
  assign w_req_op  = {req1_op, req0_op};

  // Contention goes to the requester not granted last; otherwise the lone
  // valid requester wins (req1_valid alone selects 1, req0_valid alone 0).
  assign w_win = (&w_req_vld) ? ~r_last : req1_valid;
  assign w_hs  = (r_state == IDLE) & ~rst & (|w_req_vld);

  assign req0_ready = w_hs & ~w_win;
  assign req1_ready = w_hs &  w_win;
  assign busy       = (r_state != IDLE) & ~rst;

  assign w_req_win = '{a: w_req_a[w_win], b: w_req_b[w_win],
                       op: w_req_op[w_win], id: w_win};

  // Evaluated from the captured request only, so inputs moving after the
  // handshake cannot leak into the result.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    logic_unit_arbiter_lane u_lane (
      .i_a  (r_req.a[g]),
      .i_b  (r_req.b[g]),
      .i_op (r_req.op),
      .o_y  (w_result[g])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (res_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_last      <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= 1'b0;
      r_done_cnt  <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (w_hs) begin
          r_req  <= w_req_win;
          r_last <= w_win;
        end
        EXEC: begin
          r_res_data  <= w_result;
          r_res_id    <= r_req.id;
          r_res_valid <= 1'b1;
        end
        RESP: if (res_ready) begin
          r_res_valid <= 1'b0;
          r_done_cnt  <= r_done_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;
  assign done_cnt  = r_done_cnt;

endmodule
